// File: rtl/manchester_decoder.sv
// Manchester (IEEE 802.3) line decoder: oversampled receive path that locks
// to each mid-bit transition and recovers one sync bit plus DATA_W data bits.
// Optional feature macro: MANCH_PARITY_EN (adds a trailing even-parity bit).
module manchester_decoder #(
  parameter int OVERSAMPLE = 8,
  parameter int DATA_W     = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              line_in,
  output logic              bit_out,
  output logic              bit_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              err
);

  localparam int CMAX = 5*OVERSAMPLE/4 + 1;
  localparam int CW   = $clog2(CMAX + 1);
`ifdef MANCH_PARITY_EN
  localparam int NBITS = DATA_W + 1;
`else
  localparam int NBITS = DATA_W;
`endif
  localparam int BCW = $clog2(NBITS + 1);

  localparam logic [CW-1:0]  CMAX_C = CW'(CMAX);
  localparam logic [CW-1:0]  WLO_C  = CW'(3*OVERSAMPLE/4);
  localparam logic [CW-1:0]  WHI_C  = CW'(5*OVERSAMPLE/4);
  localparam logic [BCW-1:0] LAST_C = BCW'(DATA_W - 1);
`ifdef MANCH_PARITY_EN
  localparam logic [BCW-1:0] PAR_C  = BCW'(DATA_W);
`endif

  typedef enum logic {S_IDLE, S_DATA} state_t;

  state_t            r_state, w_state_n;
  logic              r_sync1, r_line_s, r_line_d;
  logic [CW-1:0]     r_cnt, w_cnt_n;
  logic [BCW-1:0]    r_bcnt, w_bcnt_n;
  logic [DATA_W-1:0] r_shift, w_shift_n, w_shifted;
  logic              w_rise, w_fall, w_edge, w_in_win;
  logic              w_bit_out_n, w_bit_valid_n, w_data_valid_n, w_err_n;
  logic [DATA_W-1:0] w_data_out_n;

  assign w_rise    = r_line_s & ~r_line_d;
  assign w_fall    = ~r_line_s & r_line_d;
  assign w_edge    = w_rise | w_fall;
  assign w_in_win  = (r_cnt >= WLO_C) && (r_cnt <= WHI_C);
  assign w_shifted = {r_shift[DATA_W-2:0], w_rise};

  // Two-flop synchronizer plus one delay stage for edge detection
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_line_s <= 1'b0;
      r_line_d <= 1'b0;
    end else begin
      r_sync1  <= line_in;
      r_line_s <= r_sync1;
      r_line_d <= r_line_s;
    end
  end

  // State, counters, shift register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_bcnt     <= '0;
      r_shift    <= '0;
      bit_out    <= 1'b0;
      bit_valid  <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      err        <= 1'b0;
    end else begin
      r_state    <= w_state_n;
      r_cnt      <= w_cnt_n;
      r_bcnt     <= w_bcnt_n;
      r_shift    <= w_shift_n;
      bit_out    <= w_bit_out_n;
      bit_valid  <= w_bit_valid_n;
      data_out   <= w_data_out_n;
      data_valid <= w_data_valid_n;
      err        <= w_err_n;
    end
  end

  // Next-state and output decode. r_cnt holds cycles elapsed since the last
  // accepted edge with the edge cycle itself as 0, so a restart loads 1.
  always_comb begin
    w_state_n      = r_state;
    w_cnt_n        = (r_cnt == CMAX_C) ? r_cnt : r_cnt + 1'b1;
    w_bcnt_n       = r_bcnt;
    w_shift_n      = r_shift;
    w_bit_out_n    = bit_out;
    w_bit_valid_n  = 1'b0;
    w_data_out_n   = data_out;
    w_data_valid_n = 1'b0;
    w_err_n        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_rise) begin
          w_cnt_n   = CW'(1);
          w_bcnt_n  = '0;
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (w_edge && w_in_win) begin
          w_cnt_n   = CW'(1);
          w_bcnt_n  = r_bcnt + 1'b1;
          w_shift_n = w_shifted;
`ifdef MANCH_PARITY_EN
          if (r_bcnt == PAR_C) begin
            // Even parity: parity bit must equal the XOR of the data bits
            if ((^r_shift) == w_rise) begin
              w_data_out_n   = r_shift;
              w_data_valid_n = 1'b1;
            end else begin
              w_err_n = 1'b1;
            end
            w_state_n = S_IDLE;
          end else begin
            w_bit_out_n   = w_rise;
            w_bit_valid_n = 1'b1;
          end
`else
          w_bit_out_n   = w_rise;
          w_bit_valid_n = 1'b1;
          if (r_bcnt == LAST_C) begin
            w_data_out_n   = w_shifted;
            w_data_valid_n = 1'b1;
            w_state_n      = S_IDLE;
          end
`endif
        end else if (r_cnt == CMAX_C) begin
          w_err_n   = 1'b1;
          w_state_n = S_IDLE;
        end
      end
      default: w_state_n = S_IDLE;
    endcase
  end

endmodule
